// File: rtl/addsub_arb_seq_pkg.sv
// Shared types for the nibble-serial add/sub sequencer: FSM states, nibble width,
// requester index and the two's-complement overflow rule.
package addsub_arb_seq_pkg;

    localparam int NIB = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_t;

    // Operands agree in sign (B flipped for subtract) but result sign differs.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic sub, input logic r_msb);
        return (a_msb == (b_msb ^ sub)) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/addsub_arb_seq_if.sv
// Requester handshakes, shared result bus and the external 4-bit adder unit port.
// slave = sequencer side, master = requesters + adder unit side.
interface addsub_arb_seq_if
    import addsub_arb_seq_pkg::*;
#(
    parameter int NNIB = 2
);
    localparam int W = NIB * NNIB;

    logic           req0, sub0, done0;
    logic [W-1:0]   a0, b0;
    logic           req1, sub1, done1;
    logic [W-1:0]   a1, b1;
    logic [W-1:0]   result;
    logic           cout, ovf;
    logic [NIB-1:0] au_a, au_b, au_s;
    logic           au_sel, au_cin, au_cout;

    modport slave (
        input  req0, sub0, a0, b0, req1, sub1, a1, b1, au_s, au_cout,
        output done0, done1, result, cout, ovf, au_a, au_b, au_sel, au_cin
    );

    modport master (
        output req0, sub0, a0, b0, req1, sub1, a1, b1, au_s, au_cout,
        input  done0, done1, result, cout, ovf, au_a, au_b, au_sel, au_cin
    );

endinterface

// File: rtl/addsub_arb_seq_rr_arb2.sv
// Two-input round-robin arbiter; last grant starts at requester 1 so requester 0
// wins the first tie.
module rr_arb2
    import addsub_arb_seq_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_req0,
    input  logic     i_req1,
    input  logic     i_en,
    output logic     o_gnt,
    output req_idx_t o_idx
);

    req_idx_t r_last;
    req_idx_t w_idx;

    always_comb begin
        w_idx = REQ0;
        if (i_req0 && i_req1)
            w_idx = (r_last == REQ0) ? REQ1 : REQ0;
        else if (i_req1)
            w_idx = REQ1;
    end

    assign o_gnt = i_en && (i_req0 || i_req1);
    assign o_idx = w_idx;

    always_ff @(posedge clk) begin
        if (rst)
            r_last <= REQ1;
        else if (o_gnt)
            r_last <= w_idx;
    end

endmodule

// File: rtl/addsub_arb_seq.sv
// Shares one external 4-bit adder/subtractor between two requesters, running a
// W-bit add/sub one nibble per cycle (LSB first) with the carry held in a register.
module addsub_arb_seq
    import addsub_arb_seq_pkg::*;
#(
    parameter int NNIB = 2
)(
    input  logic            clk,
    input  logic            rst,
    addsub_arb_seq_if.slave bus
);

    localparam int W  = NIB * NNIB;
    localparam int KW = (NNIB > 1) ? $clog2(NNIB) : 1;

    state_e         r_state, w_state_nxt;
    logic [KW-1:0]  r_k;
    logic [W-1:0]   r_a, r_b, r_result, w_res_nxt;
    logic           r_sub, r_carry, r_cout, r_ovf;
    req_idx_t       r_idx;

    logic           w_gnt, w_last_nib;
    req_idx_t       w_gidx;
    logic [NIB-1:0] w_au_a, w_au_b;
    logic           w_au_sel, w_au_cin, w_done0, w_done1;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .i_req0 (bus.req0),
        .i_req1 (bus.req1),
        .i_en   (r_state == IDLE),
        .o_gnt  (w_gnt),
        .o_idx  (w_gidx)
    );

    assign w_last_nib = (r_k == KW'(NNIB - 1));

    always_comb begin
        w_res_nxt = r_result;
        w_res_nxt[int'(r_k) * NIB +: NIB] = bus.au_s;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt) w_state_nxt = CALC;
            CALC:    if (w_last_nib) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The adder bus is driven only while a nibble is in flight.
    always_comb begin
        w_au_a   = '0;
        w_au_b   = '0;
        w_au_sel = 1'b0;
        w_au_cin = 1'b0;
        w_done0  = 1'b0;
        w_done1  = 1'b0;
        if (r_state == CALC) begin
            w_au_a   = r_a[int'(r_k) * NIB +: NIB];
            w_au_b   = r_b[int'(r_k) * NIB +: NIB];
            w_au_sel = r_sub;
            w_au_cin = (r_k == '0) ? r_sub : r_carry;
        end
        if (r_state == DONE) begin
            w_done0 = (r_idx == REQ0);
            w_done1 = (r_idx == REQ1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_idx    <= REQ0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (r_state == IDLE && w_gnt) begin
                r_idx <= w_gidx;
                r_a   <= (w_gidx == REQ1) ? bus.a1   : bus.a0;
                r_b   <= (w_gidx == REQ1) ? bus.b1   : bus.b0;
                r_sub <= (w_gidx == REQ1) ? bus.sub1 : bus.sub0;
                r_k   <= '0;
            end
            if (r_state == CALC) begin
                r_result <= w_res_nxt;
                r_carry  <= bus.au_cout;
                r_k      <= r_k + 1'b1;
                // Flags land with the final nibble so they are valid during DONE.
                if (w_last_nib) begin
                    r_cout <= bus.au_cout;
                    r_ovf  <= add_ovf(r_a[W-1], r_b[W-1], r_sub, w_res_nxt[W-1]);
                end
            end
        end
    end

    assign bus.au_a   = w_au_a;
    assign bus.au_b   = w_au_b;
    assign bus.au_sel = w_au_sel;
    assign bus.au_cin = w_au_cin;
    assign bus.done0  = w_done0;
    assign bus.done1  = w_done1;
    assign bus.result = r_result;
    assign bus.cout   = r_cout;
    assign bus.ovf    = r_ovf;

endmodule

// File: tb/tb_addsub_arb_seq.sv
// Self-checking bench for addsub_arb_seq: behavioural adder unit, arithmetic
// reference model, directed and random operations, contention and reset abort.
module tb_addsub_arb_seq;

    localparam int NNIB   = 2;
    localparam int W      = 4 * NNIB;
    localparam int LAT    = NNIB + 1;
    localparam int BUDGET = 40;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    addsub_arb_seq_if #(.NNIB(NNIB)) bus();

    addsub_arb_seq #(.NNIB(NNIB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External adder unit: inverts B when subtracting.
    logic [4:0] au_sum;
    assign au_sum = {1'b0, bus.au_a} + {1'b0, (bus.au_sel ? ~bus.au_b : bus.au_b)} + {4'b0, bus.au_cin};
    assign bus.au_s    = au_sum[3:0];
    assign bus.au_cout = au_sum[4];

    function automatic void model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output logic v);
        longint ua, ub, s, sa, sb, rs, lim;
        ua  = longint'(a);
        ub  = longint'(b);
        lim = longint'(1) << (W - 1);
        s   = sub ? ua - ub : ua + ub;
        r   = s[W-1:0];
        c   = sub ? (ua >= ub) : (s >= (lim << 1));
        sa  = (ua >= lim) ? ua - (lim << 1) : ua;
        sb  = (ub >= lim) ? ub - (lim << 1) : ub;
        rs  = sub ? sa - sb : sa + sb;
        v   = (rs >= lim) || (rs < -lim);
    endfunction

    // Carry into nibble k, from the arithmetic of the k lower nibbles.
    function automatic logic cin_of(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        longint m, ua, ub;
        if (k == 0) return sub;
        m  = longint'(1) << (4 * k);
        ua = longint'(a) % m;
        ub = longint'(b) % m;
        if (sub) return ua >= ub;
        return (ua + ub) >= m;
    endfunction

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.sub0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.sub1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue(input int who, input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
        if (who == 0) begin
            bus.req0 = 1'b1; bus.sub0 = sub; bus.a0 = a; bus.b0 = b;
        end else begin
            bus.req1 = 1'b1; bus.sub1 = sub; bus.a1 = a; bus.b1 = b;
        end
    endtask

    task automatic wait_done(output int who, output int cyc, output bit both, output bit tmo);
        who = -1; cyc = 0; both = 1'b0; tmo = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.done0 && bus.done1) both = 1'b1;
            if (bus.done0 || bus.done1) begin
                who = bus.done0 ? 0 : 1;
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_chk++;
        if (bus.result !== '0) begin
            n_fail++; $display("FAIL reset_result: got %h expected 0", bus.result);
        end
        n_chk++;
        if ({bus.cout, bus.ovf} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: got cout=%b ovf=%b expected 0 0", bus.cout, bus.ovf);
        end
        n_chk++;
        if ({bus.done0, bus.done1} !== 2'b00) begin
            n_fail++; $display("FAIL reset_done: got %b%b expected 00", bus.done0, bus.done1);
        end
        n_chk++;
        if ({bus.au_a, bus.au_b, bus.au_sel, bus.au_cin} !== '0) begin
            n_fail++; $display("FAIL reset_au: got a=%h b=%h sel=%b cin=%b expected all 0",
                               bus.au_a, bus.au_b, bus.au_sel, bus.au_cin);
        end
    endtask

    task automatic test_carry_chain();
        int who, cyc; bit both, tmo;
        issue(0, 1'b0, W'(8'h0F), W'(8'h01));
        wait_done(who, cyc, both, tmo);
        n_chk++;
        if (tmo || who != 0 || cyc != LAT || both) begin
            n_fail++; $display("FAIL carry_handshake: got who=%0d cyc=%0d both=%0d tmo=%0d expected who=0 cyc=%0d",
                               who, cyc, both, tmo, LAT);
        end
        n_chk++;
        if ({bus.result, bus.cout, bus.ovf} !== {W'(8'h10), 2'b00}) begin
            n_fail++; $display("FAIL carry_result: got %h c=%b v=%b expected 10 c=0 v=0", bus.result, bus.cout, bus.ovf);
        end
        bus.req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ops();
        int who, cyc, ewho; bit both, tmo;
        logic sub; logic [W-1:0] a, b, er; logic ec, ev;
        for (int n = 0; n < 11; n++) begin
            case (n)
                0:       begin ewho = 0; sub = 1'b0; a = W'(8'h3C); b = W'(8'h45); end
                1:       begin ewho = 1; sub = 1'b1; a = W'(8'h10); b = W'(8'h01); end
                2:       begin ewho = 0; sub = 1'b1; a = W'(8'h00); b = W'(8'h01); end
                default: begin ewho = int'($urandom_range(0, 1)); sub = 1'($urandom); a = W'($urandom); b = W'($urandom); end
            endcase
            model(sub, a, b, er, ec, ev);
            issue(ewho, sub, a, b);
            wait_done(who, cyc, both, tmo);
            n_chk++;
            if (tmo || who != ewho || cyc != LAT || both) begin
                n_fail++; $display("FAIL op%0d_handshake: got who=%0d cyc=%0d both=%0d tmo=%0d expected who=%0d cyc=%0d",
                                   n, who, cyc, both, tmo, ewho, LAT);
            end
            n_chk++;
            if ({bus.result, bus.cout, bus.ovf} !== {er, ec, ev}) begin
                n_fail++; $display("FAIL op%0d_result: sub=%b a=%h b=%h got %h c=%b v=%b expected %h c=%b v=%b",
                                   n, sub, a, b, bus.result, bus.cout, bus.ovf, er, ec, ev);
            end
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int who, cyc, ewho, last; bit both, tmo;
        logic sub [2]; logic [W-1:0] a [2]; logic [W-1:0] b [2];
        logic [W-1:0] er; logic ec, ev;
        do_reset();
        last = 1;
        for (int r = 0; r < 2; r++) begin
            sub[r] = 1'($urandom); a[r] = W'($urandom); b[r] = W'($urandom);
            issue(r, sub[r], a[r], b[r]);
        end
        for (int n = 0; n < 6; n++) begin
            ewho = (last == 0) ? 1 : 0;
            last = ewho;
            model(sub[ewho], a[ewho], b[ewho], er, ec, ev);
            wait_done(who, cyc, both, tmo);
            n_chk++;
            if (tmo || who != ewho || both || cyc != ((n == 0) ? LAT : NNIB + 2)) begin
                n_fail++; $display("FAIL b2b%0d_order: got who=%0d cyc=%0d both=%0d tmo=%0d expected who=%0d cyc=%0d",
                                   n, who, cyc, both, tmo, ewho, (n == 0) ? LAT : NNIB + 2);
            end
            n_chk++;
            if ({bus.result, bus.cout, bus.ovf} !== {er, ec, ev}) begin
                n_fail++; $display("FAIL b2b%0d_result: got %h c=%b v=%b expected %h c=%b v=%b",
                                   n, bus.result, bus.cout, bus.ovf, er, ec, ev);
            end
            sub[ewho] = 1'($urandom); a[ewho] = W'($urandom); b[ewho] = W'($urandom);
            issue(ewho, sub[ewho], a[ewho], b[ewho]);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int who, cyc; bit both, tmo, seen;
        logic sub; logic [W-1:0] a, b, er; logic ec, ev;
        issue(0, 1'b0, W'($urandom), W'($urandom));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if ({bus.result, bus.cout, bus.ovf, bus.done0, bus.done1} !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: got r=%h c=%b v=%b d=%b%b expected all 0",
                               bus.result, bus.cout, bus.ovf, bus.done0, bus.done1);
        end
        n_chk++;
        if ({bus.au_a, bus.au_b, bus.au_sel, bus.au_cin} !== '0) begin
            n_fail++; $display("FAIL midrst_au: got a=%h b=%h sel=%b cin=%b expected all 0",
                               bus.au_a, bus.au_b, bus.au_sel, bus.au_cin);
        end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done0 || bus.done1) seen = 1'b1;
        end
        n_chk++;
        if (seen) begin
            n_fail++; $display("FAIL midrst_nodone: got a done pulse after abort expected none");
        end
        sub = 1'($urandom); a = W'($urandom); b = W'($urandom);
        model(sub, a, b, er, ec, ev);
        issue(1, sub, a, b);
        wait_done(who, cyc, both, tmo);
        n_chk++;
        if (tmo || who != 1 || cyc != LAT || both) begin
            n_fail++; $display("FAIL midrst_fresh: got who=%0d cyc=%0d tmo=%0d expected who=1 cyc=%0d", who, cyc, tmo, LAT);
        end
        n_chk++;
        if ({bus.result, bus.cout, bus.ovf} !== {er, ec, ev}) begin
            n_fail++; $display("FAIL midrst_result: got %h c=%b v=%b expected %h c=%b v=%b",
                               bus.result, bus.cout, bus.ovf, er, ec, ev);
        end
        bus.req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latch();
        logic sub; logic [W-1:0] a, b, er; logic ec, ev;
        logic [3:0] na, nb;
        n_chk++;
        if ({bus.au_a, bus.au_b, bus.au_sel, bus.au_cin} !== '0) begin
            n_fail++; $display("FAIL latch_idle_au: got a=%h b=%h sel=%b cin=%b expected all 0",
                               bus.au_a, bus.au_b, bus.au_sel, bus.au_cin);
        end
        sub = 1'($urandom); a = W'($urandom); b = W'($urandom);
        model(sub, a, b, er, ec, ev);
        issue(0, sub, a, b);
        for (int k = 0; k < NNIB; k++) begin
            @(negedge clk);
            na = a[4*k +: 4];
            nb = b[4*k +: 4];
            n_chk++;
            if ({bus.au_a, bus.au_b, bus.au_sel, bus.au_cin} !== {na, nb, sub, cin_of(sub, a, b, k)}) begin
                n_fail++; $display("FAIL latch_nib%0d: got a=%h b=%h sel=%b cin=%b expected a=%h b=%h sel=%b cin=%b",
                                   k, bus.au_a, bus.au_b, bus.au_sel, bus.au_cin, na, nb, sub, cin_of(sub, a, b, k));
            end
            if (k == 0) begin
                bus.a0 = ~a;
                bus.b0 = ~b;
            end
        end
        @(negedge clk);
        n_chk++;
        if (bus.done0 !== 1'b1 || bus.done1 !== 1'b0 ||
            {bus.au_a, bus.au_b, bus.au_sel, bus.au_cin} !== '0) begin
            n_fail++; $display("FAIL latch_done_au: got d=%b%b a=%h b=%h sel=%b cin=%b expected d=10 au all 0",
                               bus.done0, bus.done1, bus.au_a, bus.au_b, bus.au_sel, bus.au_cin);
        end
        n_chk++;
        if ({bus.result, bus.cout, bus.ovf} !== {er, ec, ev}) begin
            n_fail++; $display("FAIL latch_result: got %h c=%b v=%b expected %h c=%b v=%b",
                               bus.result, bus.cout, bus.ovf, er, ec, ev);
        end
        bus.req0 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        do_reset();
        test_reset();
        test_carry_chain();
        test_ops();
        test_back_to_back();
        test_reset_mid();
        test_latch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
